// File: rtl/reorder_buffer_if.sv
// Bus bundle for reorder_buffer: N parallel producer channels in, one serial
// consumer out, plus the completed-frame level.
//   s_stb  [N]      per-channel input valid
//   s_dat  [N*W]    channel i data in s_dat[i*W +: W]
//   s_rdy  [N]      per-channel accept (one-hot or zero)
//   m_rdy           consumer ready
//   m_stb           output valid
//   m_dat  [IW+W]   {channel index, data}
//   m_last          end-of-frame marker (channel N-1)
//   lvl    [PW+1]   completed frames still occupying a bank
// slave: the reorder buffer side.  master: the producer/consumer side.
interface reorder_buffer_if #(
  parameter int W = 8,
  parameter int N = 2,
  parameter int F = 2
);
  localparam int IW = $clog2(N);
  localparam int PW = (F > 1) ? $clog2(F) : 1;

  logic [N-1:0]    s_stb;
  logic [N*W-1:0]  s_dat;
  logic [N-1:0]    s_rdy;
  logic            m_rdy;
  logic            m_stb;
  logic [IW+W-1:0] m_dat;
  logic            m_last;
  logic [PW:0]     lvl;

  modport master (
    output s_stb, s_dat, m_rdy,
    input  s_rdy, m_stb, m_dat, m_last, lvl
  );

  modport slave (
    input  s_stb, s_dat, m_rdy,
    output s_rdy, m_stb, m_dat, m_last, lvl
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: collects one word from each of N channels into a frame bank,
// in whatever order the channels arrive, then streams the completed frame out
// in channel-index order tagged with the channel index. F banks form a ring so
// one frame can fill while an earlier one drains.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   reorder_buffer_if.slave (s_stb/s_dat/s_rdy in, m_*/lvl out)
module reorder_buffer #(
  parameter int W = 8,
  parameter int N = 2,
  parameter int F = 2
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int PW = (F > 1) ? $clog2(F) : 1;
  // Bank arrays are sized to the full pointer range so every pointer value is
  // a legal index; with F=1 the second bank is simply never addressed.
  localparam int NB = 1 << PW;
  localparam logic [PW-1:0] PTR_LAST = PW'(F - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [W-1:0]    mem_q [NB][N];
  logic [NB-1:0]   full_q,   full_d;
  logic [PW-1:0]   wb_q,     wb_d;
  logic [PW-1:0]   rb_q,     rb_d;
  logic [N-1:0]    mask_q,   mask_d;
  logic [IW-1:0]   ri_q,     ri_d;
  logic            m_stb_q,  m_stb_d;
  logic [IW+W-1:0] m_dat_q,  m_dat_d;
  logic            m_last_q, m_last_d;
  logic [PW:0]     lvl_q,    lvl_d;

  logic            wr_open;
  logic [N-1:0]    elig;
  logic [N-1:0]    grant;
  logic [IW-1:0]   widx;
  logic [W-1:0]    wdat;
  logic            wr;
  logic            wr_done;
  logic            ld;
  logic            rd_done;

  // Write arbitration: lowest-index channel that has not yet contributed to
  // the open bank. Gated by rst so s_rdy reads 0 throughout reset.
  always_comb begin
    wr_open = ~full_q[wb_q];
    elig    = bus.s_stb & ~mask_q & {N{wr_open & ~rst}};
    grant   = elig & (~elig + N'(1));
  end

  always_comb begin
    widx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) widx = IW'(i);
    end
  end

  assign wdat    = bus.s_dat[widx*W +: W];
  assign wr      = |grant;
  assign wr_done = wr && ((mask_q | grant) == '1);

  assign ld      = full_q[rb_q] && (!m_stb_q || bus.m_rdy);
  assign rd_done = ld && (ri_q == IDX_LAST);

  always_comb begin
    full_d   = full_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    mask_d   = mask_q;
    ri_d     = ri_q;
    m_stb_d  = m_stb_q;
    m_dat_d  = m_dat_q;
    m_last_d = m_last_q;
    lvl_d    = lvl_q;

    if (wr) begin
      if (wr_done) begin
        full_d[wb_q] = 1'b1;
        mask_d       = '0;
        wb_d         = (wb_q == PTR_LAST) ? '0 : wb_q + 1'b1;
      end else begin
        mask_d = mask_q | grant;
      end
    end

    // A completing write and a freeing read never target the same bank:
    // the write bank is empty and the read bank is full.
    if (ld) begin
      m_stb_d  = 1'b1;
      m_dat_d  = {ri_q, mem_q[rb_q][ri_q]};
      m_last_d = rd_done;
      if (rd_done) begin
        ri_d         = '0;
        full_d[rb_q] = 1'b0;
        rb_d         = (rb_q == PTR_LAST) ? '0 : rb_q + 1'b1;
      end else begin
        ri_d = ri_q + 1'b1;
      end
    end else if (m_stb_q && bus.m_rdy) begin
      m_stb_d = 1'b0;
    end

    case ({wr_done, rd_done})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= '0;
      wb_q     <= '0;
      rb_q     <= '0;
      mask_q   <= '0;
      ri_q     <= '0;
      m_stb_q  <= 1'b0;
      m_dat_q  <= '0;
      m_last_q <= 1'b0;
      lvl_q    <= '0;
    end else begin
      full_q   <= full_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      mask_q   <= mask_d;
      ri_q     <= ri_d;
      m_stb_q  <= m_stb_d;
      m_dat_q  <= m_dat_d;
      m_last_q <= m_last_d;
      lvl_q    <= lvl_d;
    end
  end

  // Frame storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wb_q][widx] <= wdat;
  end

  assign bus.s_rdy  = grant;
  assign bus.m_stb  = m_stb_q;
  assign bus.m_dat  = m_dat_q;
  assign bus.m_last = m_last_q;
  assign bus.lvl    = lvl_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: two instances (N=4, W=8, F=2 and F=1) share the
// same stimulus; one is selected for checking at a time. A queue-of-frames
// reference model predicts s_rdy, lvl and the output register every cycle.
module tb_reorder_buffer;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   s_stb = '0;
  logic [N*W-1:0] s_dat = '0;
  logic           m_rdy = 1'b0;
  bit             sel   = 1'b0;

  reorder_buffer_if #(.W(W), .N(N), .F(2)) bus0 ();
  reorder_buffer_if #(.W(W), .N(N), .F(1)) bus1 ();

  assign bus0.s_stb = s_stb;
  assign bus0.s_dat = s_dat;
  assign bus0.m_rdy = m_rdy;
  assign bus1.s_stb = s_stb;
  assign bus1.s_dat = s_dat;
  assign bus1.m_rdy = m_rdy;

  reorder_buffer #(.W(W), .N(N), .F(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  reorder_buffer #(.W(W), .N(N), .F(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [N-1:0]    o_srdy;
  logic            o_mstb;
  logic            o_mlast;
  logic [IW+W-1:0] o_mdat;
  logic [1:0]      o_lvl;

  assign o_srdy  = sel ? bus1.s_rdy  : bus0.s_rdy;
  assign o_mstb  = sel ? bus1.m_stb  : bus0.m_stb;
  assign o_mlast = sel ? bus1.m_last : bus0.m_last;
  assign o_mdat  = sel ? bus1.m_dat  : bus0.m_dat;
  assign o_lvl   = sel ? bus1.lvl    : bus0.lvl;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  int unsigned     mF;
  logic [N*W-1:0]  cur;
  logic [N-1:0]    cmask;
  logic [N*W-1:0]  frames[$];
  int unsigned     rd_idx;
  bit              out_v;
  bit              out_last;
  logic [IW+W-1:0] out_w;
  logic [IW+W:0]   seen[$];

  task automatic model_reset();
    cur      = '0;
    cmask    = '0;
    frames.delete();
    rd_idx   = 0;
    out_v    = 1'b0;
    out_last = 1'b0;
    out_w    = '0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, " s_rdy"},  32'(o_srdy),  32'd0);
    chk({pfx, " m_stb"},  32'(o_mstb),  32'd0);
    chk({pfx, " m_dat"},  32'(o_mdat),  32'd0);
    chk({pfx, " m_last"}, 32'(o_mlast), 32'd0);
    chk({pfx, " lvl"},    32'(o_lvl),   32'd0);
  endtask

  function automatic logic [N*W-1:0] one(input int ch, input logic [W-1:0] v);
    logic [N*W-1:0] d;
    d = '0;
    d[ch*W +: W] = v;
    return d;
  endfunction

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [N-1:0] stb, input logic [N*W-1:0] dat, input bit rdy);
    logic [N-1:0]   eg;
    logic [N*W-1:0] head;
    bit             load;
    s_stb = stb;
    s_dat = dat;
    m_rdy = rdy;
    #1;
    eg = '0;
    if (frames.size() < mF) begin
      for (int i = 0; i < N; i++) begin
        if (stb[i] && !cmask[i]) begin
          eg[i] = 1'b1;
          break;
        end
      end
    end
    chk("s_rdy", 32'(o_srdy), 32'(eg));
    chk("lvl",   32'(o_lvl),  32'(frames.size()));
    chk("m_stb", 32'(o_mstb), 32'(out_v));
    if (out_v) begin
      chk("m_dat",  32'(o_mdat),  32'(out_w));
      chk("m_last", 32'(o_mlast), 32'(out_last));
    end
    if (o_mstb && rdy) seen.push_back({o_mlast, o_mdat});

    load = (frames.size() > 0) && (!out_v || rdy);
    if (load) begin
      head     = frames[0];
      out_w    = {IW'(rd_idx), head[rd_idx*W +: W]};
      out_last = (rd_idx == N - 1);
      out_v    = 1'b1;
      if (rd_idx == N - 1) begin
        void'(frames.pop_front());
        rd_idx = 0;
      end else begin
        rd_idx++;
      end
    end else if (out_v && rdy) begin
      out_v = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (eg[i]) begin
        cur[i*W +: W] = dat[i*W +: W];
        cmask[i]      = 1'b1;
      end
    end
    if (cmask == '1) begin
      frames.push_back(cur);
      cmask = '0;
    end
    @(negedge clk);
  endtask

  // Reset asserted between clock edges; outputs must fall without a clock.
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk_zero("async rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [IW+W:0] e;
    mF = 2;
    sel = 1'b0;
    model_reset();
    @(negedge clk);
    s_stb = '1;
    s_dat = 32'hDEADBEEF;
    #1;
    chk_zero("reset");
    s_stb = '0;
    @(negedge clk);
    rst = 1'b0;

    // Out-of-order single frame
    seen.delete();
    cycle(4'b1000, one(3, 8'h33), 1'b1);
    cycle(4'b0010, one(1, 8'h11), 1'b1);
    cycle(4'b0001, one(0, 8'h00), 1'b1);
    cycle(4'b0100, one(2, 8'h22), 1'b1);
    repeat (8) cycle('0, '0, 1'b1);
    chk("ooo count", 32'(seen.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      e = {(k == 3), IW'(k), W'(k * 8'h11)};
      if (k < seen.size()) chk("ooo word", 32'(seen[k]), 32'(e));
    end

    // Reset after two accepted words, then a clean frame from all-strobes
    seen.delete();
    cycle(4'b0001, one(0, 8'h5A), 1'b1);
    cycle(4'b0010, one(1, 8'h5B), 1'b1);
    mid_reset();
    repeat (4) cycle(4'b1111, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    repeat (8) cycle('0, '0, 1'b1);
    chk("post-rst count", 32'(seen.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      e = {(k == 3), IW'(k), W'(8'hA0 + k)};
      if (k < seen.size()) chk("post-rst word", 32'(seen[k]), 32'(e));
    end

    // Randomized traffic on each configuration with varying consumer rates
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      mF  = (s == 1) ? 1 : 2;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < 250; c++) begin
          logic [N-1:0]   stb;
          logic [N*W-1:0] d;
          bit             r;
          stb = N'($urandom);
          d   = $urandom;
          case (p)
            0:       r = ($urandom_range(0, 1) == 1);
            1:       r = ($urandom_range(0, 9) == 0);
            2:       r = 1'b1;
            default: r = c[0];
          endcase
          if ($urandom_range(0, 299) == 0) mid_reset();
          else cycle(stb, d, r);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
